hwpe_dyn_ctrl: RTL and testbench

HWPE_DYN_CTRL -- requirements
Module: hwpe_dyn_ctrl

---
 rtl/hwpe_dyn_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_hwpe_dyn_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_dyn_ctrl.sv
// hwpe_dyn_ctrl: dynamic power/clock controller for a cluster of HWPEs.
// Per-HWPE OFF/ON/DRAIN clock gating, a config-bus demux with an error
// responder, a locking round-robin TCDM arbiter and event/busy aggregation.
module hwpe_dyn_ctrl #(
    parameter int N_HWPES  = 3,
    parameter int N_CORES  = 8,
    parameter int ID_WIDTH = 8,
    parameter int AW       = 32,
    parameter int DW       = 288,
    parameter int SEL_LSB  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_HWPES-1:0]            hwpe_en_i,
    output logic [N_HWPES-1:0]            hwpe_clk_en_o,
    // config target port
    input  logic                          cfg_req,
    input  logic [31:0]                   cfg_add,
    input  logic                          cfg_wen,
    input  logic [3:0]                    cfg_be,
    input  logic [31:0]                   cfg_wdata,
    input  logic [ID_WIDTH-1:0]           cfg_id,
    output logic                          cfg_gnt,
    output logic                          cfg_r_valid,
    output logic [31:0]                   cfg_r_rdata,
    output logic [ID_WIDTH-1:0]           cfg_r_id,
    // per-HWPE config initiator ports (request fields broadcast)
    output logic [N_HWPES-1:0]            hp_cfg_req,
    output logic [31:0]                   hp_cfg_add,
    output logic                          hp_cfg_wen,
    output logic [3:0]                    hp_cfg_be,
    output logic [31:0]                   hp_cfg_wdata,
    output logic [ID_WIDTH-1:0]           hp_cfg_id,
    input  logic [N_HWPES-1:0]            hp_cfg_gnt,
    input  logic [N_HWPES-1:0]            hp_cfg_r_valid,
    input  logic [N_HWPES*32-1:0]         hp_cfg_r_rdata,
    input  logic [N_HWPES*ID_WIDTH-1:0]   hp_cfg_r_id,
    // HWPE TCDM initiators
    input  logic [N_HWPES-1:0]            hp_tcdm_req,
    input  logic [N_HWPES*AW-1:0]         hp_tcdm_add,
    input  logic [N_HWPES-1:0]            hp_tcdm_wen,
    input  logic [N_HWPES*(DW/8)-1:0]     hp_tcdm_be,
    input  logic [N_HWPES*DW-1:0]         hp_tcdm_data,
    output logic [N_HWPES-1:0]            hp_tcdm_gnt,
    output logic [N_HWPES-1:0]            hp_tcdm_r_valid,
    output logic [DW-1:0]                 hp_tcdm_r_data,
    // shared TCDM port
    output logic                          tcdm_req,
    output logic [AW-1:0]                 tcdm_add,
    output logic                          tcdm_wen,
    output logic [DW/8-1:0]               tcdm_be,
    output logic [DW-1:0]                 tcdm_data,
    input  logic                          tcdm_gnt,
    input  logic                          tcdm_r_valid,
    input  logic [DW-1:0]                 tcdm_r_data,
    // status
    input  logic [N_HWPES-1:0]            hp_busy_i,
    input  logic [N_HWPES*N_CORES*2-1:0]  hp_evt_i,
    output logic [N_CORES*2-1:0]          evt_o,
    output logic                          busy_o
);

    localparam int SW = (N_HWPES > 1) ? $clog2(N_HWPES) : 1;
    localparam int BW = DW / 8;
    localparam int EW = N_CORES * 2;

    typedef enum logic [1:0] {ST_OFF = 2'd0, ST_ON = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t            state_reg  [N_HWPES];
    state_t            state_next [N_HWPES];
    logic [N_HWPES-1:0] active;
    logic               drain_any;

    // ---------------- per-HWPE power FSMs ----------------

    // State register for every HWPE FSM
    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < N_HWPES; i++) begin
            if (rst) state_reg[i] <= ST_OFF;
            else     state_reg[i] <= state_next[i];
        end
    end

    // Next-state: a re-enable while draining wins over finishing the drain
    always_comb begin
        for (int i = 0; i < N_HWPES; i++) begin
            state_next[i] = state_reg[i];
            case (state_reg[i])
                ST_OFF:   if (hwpe_en_i[i]) state_next[i] = ST_ON;
                ST_ON:    if (!hwpe_en_i[i]) state_next[i] = hp_busy_i[i] ? ST_DRAIN : ST_OFF;
                ST_DRAIN: if (hwpe_en_i[i]) state_next[i] = ST_ON;
                          else if (!hp_busy_i[i]) state_next[i] = ST_OFF;
                default:  state_next[i] = ST_OFF;
            endcase
        end
    end

    // FSM outputs: clock enable follows any non-OFF state
    always_comb begin
        drain_any = 1'b0;
        for (int i = 0; i < N_HWPES; i++) begin
            active[i] = (state_reg[i] != ST_OFF);
            if (state_reg[i] == ST_DRAIN) drain_any = 1'b1;
        end
        hwpe_clk_en_o = active;
    end

    assign busy_o = (|hp_busy_i) | drain_any;

    // ---------------- configuration path ----------------
    logic                pending_reg, err_reg;
    logic [SW-1:0]       tgt_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic [SW-1:0]       tgt;
    logic                tgt_ok, tgt_gnt, can_issue;

    assign tgt          = cfg_add[SEL_LSB +: SW];
    assign hp_cfg_add   = cfg_add;
    assign hp_cfg_wen   = cfg_wen;
    assign hp_cfg_be    = cfg_be;
    assign hp_cfg_wdata = cfg_wdata;
    assign hp_cfg_id    = cfg_id;

    // Demux the request, route the response back from the stored target
    always_comb begin
        tgt_ok      = 1'b0;
        tgt_gnt     = 1'b0;
        cfg_r_valid = 1'b0;
        cfg_r_rdata = '0;
        cfg_r_id    = '0;
        hp_cfg_req  = '0;
        cfg_gnt     = 1'b0;
        for (int i = 0; i < N_HWPES; i++) begin
            if (tgt == SW'(i)) begin
                tgt_ok  = active[i];
                tgt_gnt = hp_cfg_gnt[i];
            end
        end
        if (pending_reg) begin
            if (err_reg) begin
                cfg_r_valid = 1'b1;
                cfg_r_rdata = 32'hDEADBEEF;
                cfg_r_id    = id_reg;
            end else begin
                for (int i = 0; i < N_HWPES; i++) begin
                    if (tgt_reg == SW'(i)) begin
                        cfg_r_valid = hp_cfg_r_valid[i];
                        cfg_r_rdata = hp_cfg_r_rdata[i*32 +: 32];
                        cfg_r_id    = hp_cfg_r_id[i*ID_WIDTH +: ID_WIDTH];
                    end
                end
            end
        end
        // a response retiring this cycle frees the slot for a new grant
        can_issue = !pending_reg || cfg_r_valid;
        if (can_issue && cfg_req) begin
            if (tgt_ok) begin
                for (int i = 0; i < N_HWPES; i++)
                    hp_cfg_req[i] = (tgt == SW'(i));
                cfg_gnt = tgt_gnt;
            end else begin
                cfg_gnt = 1'b1;
            end
        end
    end

    // Outstanding-transaction tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
            tgt_reg     <= '0;
            id_reg      <= '0;
        end else if (cfg_req && cfg_gnt) begin
            pending_reg <= 1'b1;
            err_reg     <= !tgt_ok;
            tgt_reg     <= tgt;
            id_reg      <= cfg_id;
        end else if (cfg_r_valid) begin
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
        end
    end

    // ---------------- TCDM arbitration ----------------
    logic [AW-1:0]     add_arr  [N_HWPES];
    logic [BW-1:0]     be_arr   [N_HWPES];
    logic [DW-1:0]     data_arr [N_HWPES];
    logic [EW-1:0]     evt_masked [N_HWPES];
    logic [N_HWPES-1:0] elig;

    for (genvar gi = 0; gi < N_HWPES; gi++) begin : gen_unpack
        assign add_arr[gi]    = hp_tcdm_add[gi*AW +: AW];
        assign be_arr[gi]     = hp_tcdm_be[gi*BW +: BW];
        assign data_arr[gi]   = hp_tcdm_data[gi*DW +: DW];
        assign elig[gi]       = hp_tcdm_req[gi] & active[gi];
        assign evt_masked[gi] = active[gi] ? hp_evt_i[gi*EW +: EW] : '0;
    end

    logic          lock_reg, rsp_pend_reg;
    logic [SW-1:0] lock_idx_reg, ptr_reg, rsp_idx_reg;
    logic          win_valid;
    logic [SW-1:0] win_idx;

    // Winner: keep a stalled winner while it is still eligible, else round-robin
    always_comb begin
        int cand;
        cand      = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        if (lock_reg && elig[lock_idx_reg]) begin
            win_valid = 1'b1;
            win_idx   = lock_idx_reg;
        end else begin
            for (int k = 0; k < N_HWPES; k++) begin
                cand = int'(ptr_reg) + k;
                if (cand >= N_HWPES) cand = cand - N_HWPES;
                if (!win_valid && elig[cand]) begin
                    win_valid = 1'b1;
                    win_idx   = SW'(cand);
                end
            end
        end
    end

    // Forward the winner and route grant / response strobes
    always_comb begin
        tcdm_req  = win_valid;
        tcdm_add  = add_arr[win_idx];
        tcdm_wen  = hp_tcdm_wen[win_idx];
        tcdm_be   = be_arr[win_idx];
        tcdm_data = data_arr[win_idx];
        for (int i = 0; i < N_HWPES; i++) begin
            hp_tcdm_gnt[i]     = win_valid && tcdm_gnt && (win_idx == SW'(i));
            hp_tcdm_r_valid[i] = rsp_pend_reg && tcdm_r_valid && (rsp_idx_reg == SW'(i));
        end
    end

    assign hp_tcdm_r_data = tcdm_r_data;

    // Arbiter state: pointer, lock and response routing index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            rsp_idx_reg  <= '0;
            rsp_pend_reg <= 1'b0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            rsp_pend_reg <= win_valid && tcdm_gnt;
            if (win_valid && tcdm_gnt) begin
                ptr_reg     <= (int'(win_idx) == N_HWPES - 1) ? '0 : win_idx + SW'(1);
                rsp_idx_reg <= win_idx;
                lock_reg    <= 1'b0;
            end else if (win_valid) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= win_idx;
            end else begin
                lock_reg <= 1'b0;
            end
        end
    end

    // ---------------- event aggregation ----------------
    logic [EW-1:0] evt_reg, evt_next;

    // OR events of all powered HWPEs
    always_comb begin
        evt_next = '0;
        for (int i = 0; i < N_HWPES; i++) evt_next = evt_next | evt_masked[i];
    end

    // Register the aggregated events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) evt_reg <= '0;
        else     evt_reg <= evt_next;
    end

    assign evt_o = evt_reg;

endmodule

// File: tb/tb_hwpe_dyn_ctrl.sv
// Directed bench for hwpe_dyn_ctrl with hand-computed expectations.
module tb_hwpe_dyn_ctrl;
    localparam int N = 3, NC = 8, IDW = 8, AW = 32, DW = 288, BW = DW/8, EW = NC*2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]       hwpe_en_i, hwpe_clk_en_o;
    logic               cfg_req, cfg_wen, cfg_gnt, cfg_r_valid;
    logic [31:0]        cfg_add, cfg_wdata, cfg_r_rdata;
    logic [3:0]         cfg_be;
    logic [IDW-1:0]     cfg_id, cfg_r_id;
    logic [N-1:0]       hp_cfg_req, hp_cfg_gnt, hp_cfg_r_valid;
    logic [31:0]        hp_cfg_add, hp_cfg_wdata;
    logic               hp_cfg_wen;
    logic [3:0]         hp_cfg_be;
    logic [IDW-1:0]     hp_cfg_id;
    logic [N*32-1:0]    hp_cfg_r_rdata;
    logic [N*IDW-1:0]   hp_cfg_r_id;
    logic [N-1:0]       hp_tcdm_req, hp_tcdm_wen, hp_tcdm_gnt, hp_tcdm_r_valid;
    logic [N*AW-1:0]    hp_tcdm_add;
    logic [N*BW-1:0]    hp_tcdm_be;
    logic [N*DW-1:0]    hp_tcdm_data;
    logic [DW-1:0]      hp_tcdm_r_data;
    logic               tcdm_req, tcdm_wen, tcdm_gnt, tcdm_r_valid;
    logic [AW-1:0]      tcdm_add;
    logic [BW-1:0]      tcdm_be;
    logic [DW-1:0]      tcdm_data, tcdm_r_data;
    logic [N-1:0]       hp_busy_i;
    logic [N*EW-1:0]    hp_evt_i;
    logic [EW-1:0]      evt_o;
    logic               busy_o;

    hwpe_dyn_ctrl #(.N_HWPES(N), .N_CORES(NC), .ID_WIDTH(IDW), .AW(AW), .DW(DW), .SEL_LSB(8)) dut (
        .clk(clk), .rst(rst),
        .hwpe_en_i(hwpe_en_i), .hwpe_clk_en_o(hwpe_clk_en_o),
        .cfg_req(cfg_req), .cfg_add(cfg_add), .cfg_wen(cfg_wen), .cfg_be(cfg_be),
        .cfg_wdata(cfg_wdata), .cfg_id(cfg_id), .cfg_gnt(cfg_gnt),
        .cfg_r_valid(cfg_r_valid), .cfg_r_rdata(cfg_r_rdata), .cfg_r_id(cfg_r_id),
        .hp_cfg_req(hp_cfg_req), .hp_cfg_add(hp_cfg_add), .hp_cfg_wen(hp_cfg_wen),
        .hp_cfg_be(hp_cfg_be), .hp_cfg_wdata(hp_cfg_wdata), .hp_cfg_id(hp_cfg_id),
        .hp_cfg_gnt(hp_cfg_gnt), .hp_cfg_r_valid(hp_cfg_r_valid),
        .hp_cfg_r_rdata(hp_cfg_r_rdata), .hp_cfg_r_id(hp_cfg_r_id),
        .hp_tcdm_req(hp_tcdm_req), .hp_tcdm_add(hp_tcdm_add), .hp_tcdm_wen(hp_tcdm_wen),
        .hp_tcdm_be(hp_tcdm_be), .hp_tcdm_data(hp_tcdm_data), .hp_tcdm_gnt(hp_tcdm_gnt),
        .hp_tcdm_r_valid(hp_tcdm_r_valid), .hp_tcdm_r_data(hp_tcdm_r_data),
        .tcdm_req(tcdm_req), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be),
        .tcdm_data(tcdm_data), .tcdm_gnt(tcdm_gnt), .tcdm_r_valid(tcdm_r_valid),
        .tcdm_r_data(tcdm_r_data),
        .hp_busy_i(hp_busy_i), .hp_evt_i(hp_evt_i), .evt_o(evt_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("[%0t] %-14s obs=%0h ok", $time, tag, obs);
        end else begin
            $display("[%0t] FAIL %s: observed %0h, expected %0h", $time, tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (drive point)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle (sample point)
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        hwpe_en_i = '1;  // reset must dominate enable
        cfg_req = 0; cfg_add = '0; cfg_wen = 0; cfg_be = 4'hF; cfg_wdata = '0; cfg_id = '0;
        hp_cfg_gnt = '0; hp_cfg_r_valid = '0; hp_cfg_r_rdata = '0; hp_cfg_r_id = '0;
        hp_tcdm_req = '0; hp_tcdm_wen = '0; hp_tcdm_be = '1; hp_tcdm_data = '0; hp_tcdm_add = '0;
        for (int i = 0; i < N; i++) hp_tcdm_add[i*AW +: AW] = 32'h1000 + i;
        tcdm_gnt = 0; tcdm_r_valid = 0; tcdm_r_data = '0;
        hp_busy_i = '0; hp_evt_i = '0;

        // ---- reset state ----
        step(); step();
        sample();
        check("rst_clk_en", hwpe_clk_en_o, 0);
        check("rst_evt", evt_o, 0);
        check("rst_cfg_rv", cfg_r_valid, 0);
        check("rst_tcdm_rv", hp_tcdm_r_valid, 0);
        check("rst_tcdm_req", tcdm_req, 0);
        hwpe_en_i = '0;
        step(); rst = 0;
        sample();
        check("post_rst_en", hwpe_clk_en_o, 0);

        // ---- enable HWPE1: visible one cycle later ----
        step(); hwpe_en_i = 3'b010;
        sample(); check("en1_c0", hwpe_clk_en_o, 3'b000);
        step();
        sample(); check("en1_c1", hwpe_clk_en_o, 3'b010);

        // ---- cfg to OFF HWPE2 -> error response ----
        step(); cfg_req = 1; cfg_add = 32'h200; cfg_id = 8'h5A;
        sample();
        check("err2_gnt", cfg_gnt, 1);
        check("err2_hpreq", hp_cfg_req, 0);
        step(); cfg_req = 0;
        sample();
        check("err2_rv", cfg_r_valid, 1);
        check("err2_rdata", cfg_r_rdata, 32'hDEADBEEF);
        check("err2_rid", cfg_r_id, 8'h5A);
        step();
        sample(); check("err2_rv_end", cfg_r_valid, 0);

        // ---- cfg to out-of-range target 3 ----
        step(); cfg_req = 1; cfg_add = 32'h300; cfg_id = 8'hA5;
        sample(); check("err3_gnt", cfg_gnt, 1);
        step(); cfg_req = 0;
        sample();
        check("err3_rv", cfg_r_valid, 1);
        check("err3_rid", cfg_r_id, 8'hA5);

        // ---- cfg to ON HWPE1: pass-through, single outstanding ----
        step(); cfg_req = 1; cfg_add = 32'h104; cfg_id = 8'h11; hp_cfg_gnt = 3'b010;
        sample();
        check("cfg1_hpreq", hp_cfg_req, 3'b010);
        check("cfg1_gnt", cfg_gnt, 1);
        step();
        sample();
        check("cfg1_blk_gnt", cfg_gnt, 0);
        check("cfg1_blk_req", hp_cfg_req, 0);
        step();
        hp_cfg_r_valid = 3'b010;
        hp_cfg_r_rdata[1*32 +: 32] = 32'h12345678;
        hp_cfg_r_id[1*IDW +: IDW] = 8'h33;
        sample();
        check("cfg1_rv", cfg_r_valid, 1);
        check("cfg1_rdata", cfg_r_rdata, 32'h12345678);
        check("cfg1_rid", cfg_r_id, 8'h33);
        check("cfg1_regnt", cfg_gnt, 1);
        step(); cfg_req = 0; hp_cfg_r_valid = '0;
        sample(); check("cfg1_wait", cfg_r_valid, 0);
        step(); hp_cfg_r_valid = 3'b010;
        sample(); check("cfg1_rv2", cfg_r_valid, 1);
        step(); hp_cfg_r_valid = '0; hp_cfg_gnt = '0;

        // ---- all HWPEs on ----
        hwpe_en_i = 3'b111;
        step();
        sample(); check("all_on", hwpe_clk_en_o, 3'b111);

        // ---- round-robin with continuous grant ----
        step(); hp_tcdm_req = 3'b111; tcdm_gnt = 1; tcdm_r_valid = 1;
        for (int k = 0; k < 6; k++) begin
            sample();
            check($sformatf("rr_gnt%0d", k), hp_tcdm_gnt, 3'b001 << (k % 3));
            check($sformatf("rr_add%0d", k), tcdm_add, 32'h1000 + (k % 3));
            check($sformatf("rr_rv%0d", k), hp_tcdm_r_valid,
                  (k == 0) ? 3'b000 : (3'b001 << ((k - 1) % 3)));
            step();
        end

        // ---- stall: HWPE1 locked while HWPE0/2 also request ----
        tcdm_gnt = 0; tcdm_r_valid = 0; hp_tcdm_req = 3'b110;
        sample();
        check("stall0_add", tcdm_add, 32'h1001);
        check("stall0_gnt", hp_tcdm_gnt, 0);
        step(); hp_tcdm_req = 3'b111;
        for (int s = 1; s < 3; s++) begin
            sample();
            check($sformatf("stall%0d_add", s), tcdm_add, 32'h1001);
            check($sformatf("stall%0d_gnt", s), hp_tcdm_gnt, 0);
            step();
        end
        tcdm_gnt = 1;
        sample(); check("stall_rel_gnt", hp_tcdm_gnt, 3'b010);
        step(); tcdm_r_valid = 1;
        sample();
        check("after_gnt", hp_tcdm_gnt, 3'b100);
        check("after_rv", hp_tcdm_r_valid, 3'b010);
        step(); hp_tcdm_req = '0; tcdm_gnt = 0; tcdm_r_valid = 0;

        // ---- drain: en[1] drops while busy for 5 cycles ----
        hwpe_en_i = 3'b101; hp_busy_i = 3'b010;
        for (int d = 0; d < 5; d++) begin
            sample();
            check($sformatf("drain%0d_en", d), hwpe_clk_en_o, 3'b111);
            check($sformatf("drain%0d_busy", d), busy_o, 1);
            step();
        end
        hp_busy_i = '0;
        sample();
        check("drain_last_en", hwpe_clk_en_o, 3'b111);
        check("drain_last_bsy", busy_o, 1);
        step();
        sample();
        check("drain_off_en", hwpe_clk_en_o, 3'b101);
        check("drain_off_bsy", busy_o, 0);

        // ---- OFF requester ignored, events masked ----
        step();
        hp_tcdm_req = 3'b010;
        hp_evt_i[0*EW +: EW] = 16'h0001;
        hp_evt_i[1*EW +: EW] = 16'h0100;
        hp_evt_i[2*EW +: EW] = 16'h8000;
        sample();
        check("off_req", tcdm_req, 0);
        check("off_gnt", hp_tcdm_gnt, 0);
        step();
        sample(); check("evt_or", evt_o, 16'h8001);
        step(); hp_tcdm_req = '0; hp_evt_i = '0;

        // ---- reset during pending cfg to HWPE0 ----
        cfg_req = 1; cfg_add = 32'h000; cfg_id = 8'h77; hp_cfg_gnt = 3'b001;
        sample();
        check("rcfg_gnt", cfg_gnt, 1);
        check("rcfg_hpreq", hp_cfg_req, 3'b001);
        step(); cfg_req = 0; hp_cfg_gnt = '0; rst = 1; hp_cfg_r_valid = 3'b001;
        sample();
        check("rcfg_rv_rst", cfg_r_valid, 0);
        check("rcfg_clk_en", hwpe_clk_en_o, 0);
        step(); rst = 0;
        sample(); check("rcfg_late_rv", cfg_r_valid, 0);
        step();
        sample(); check("rcfg_late_rv2", cfg_r_valid, 0);
        step(); hp_cfg_r_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
